// File: rtl/elevator_ctrl_n_if.sv
// ----------------------------------------------------------------------------
// elevator_ctrl_n_if
// Bundles the call panels and the status outputs of the N-floor elevator
// controller.
//   master modport : the side that drives the call panels and reads status
//                    (elevator top level or testbench)
//   slave modport  : the controller itself
// Signals:
//   interior_panel [NUM_FLOORS] cabin call buttons, bit i = floor i
//   exterior_panel [NUM_FLOORS] hall call buttons, bit i = floor i
//   engine         [2]          00 off, 10 moving up, 11 moving down
//   doors          [NUM_FLOORS] one-hot open door, all zero = closed
//   current_floor  [FW]         floor the cabin is at or last passed
//   requests       [NUM_FLOORS] pending latched calls
//   direction      [1]          1 = up, 0 = down
// ----------------------------------------------------------------------------
interface elevator_ctrl_n_if #(
   parameter int NUM_FLOORS = 4
);
   localparam int FW = $clog2(NUM_FLOORS);

   logic [NUM_FLOORS-1:0] interior_panel;
   logic [NUM_FLOORS-1:0] exterior_panel;
   logic [1:0]            engine;
   logic [NUM_FLOORS-1:0] doors;
   logic [FW-1:0]         current_floor;
   logic [NUM_FLOORS-1:0] requests;
   logic                  direction;

   modport master (
      output interior_panel, exterior_panel,
      input  engine, doors, current_floor, requests, direction
   );

   modport slave (
      input  interior_panel, exterior_panel,
      output engine, doors, current_floor, requests, direction
   );
endinterface

// File: rtl/elevator_ctrl_n.sv
// ----------------------------------------------------------------------------
// elevator_ctrl_n
// N-floor elevator controller. Latches cabin and hall calls, serves them in
// SCAN order (keeps its direction while calls remain ahead), and times the
// hop between adjacent floors and the door dwell with internal counters.
// All outputs are registered.
// Ports:
//   CLK   system clock, rising edge active
//   RST   synchronous reset, active high
//   estop emergency stop (present only when ELEVATOR_ESTOP_EN is defined):
//         engine off, counters frozen, calls still latch
//   elev  elevator_ctrl_n_if.slave: call panels in, engine/doors/floor/
//         requests/direction out
// Optional feature macro: ELEVATOR_ESTOP_EN
// ----------------------------------------------------------------------------
module elevator_ctrl_n #(
   parameter int NUM_FLOORS    = 4,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3,
   parameter int FW            = $clog2(NUM_FLOORS)
) (
   input  logic             CLK,
   input  logic             RST,
`ifdef ELEVATOR_ESTOP_EN
   input  logic             estop,
`endif
   elevator_ctrl_n_if.slave elev
);
   localparam int TCW = $clog2(TRAVEL_CYCLES) + 1;
   localparam int DCW = $clog2(DOOR_CYCLES) + 1;
   localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);
   localparam logic [TCW-1:0]        TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
   localparam logic [DCW-1:0]        DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0]         TOP_FLOOR   = FW'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   state_t                state_reg, state_next, pick_state;
   logic [FW-1:0]         floor_reg, floor_next;
   logic [NUM_FLOORS-1:0] requests_reg, requests_next;
   logic                  direction_reg, direction_next, pick_dir;
   logic [TCW-1:0]        travel_cnt_reg, travel_cnt_next;
   logic [DCW-1:0]        door_cnt_reg, door_cnt_next;
   logic [1:0]            engine_reg, engine_next;
   logic [NUM_FLOORS-1:0] doors_reg, doors_next;

   logic [NUM_FLOORS-1:0] above_vec, below_vec, here_onehot;
   logic [NUM_FLOORS-1:0] calls, latch_calls, clear_mask, arrive_onehot;
   logic                  above, below, here, door_recall, halted;

`ifdef ELEVATOR_ESTOP_EN
   assign halted = estop;
`else
   assign halted = 1'b0;
`endif

   // Per-floor classification of pending calls relative to the cabin.
   generate
      for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
         assign above_vec[gi] = requests_reg[gi] && (FW'(gi) > floor_reg);
         assign below_vec[gi] = requests_reg[gi] && (FW'(gi) < floor_reg);
      end
   endgenerate

   assign above       = |above_vec;
   assign below       = |below_vec;
   assign here_onehot = ONE << floor_reg;
   assign here        = |(requests_reg & here_onehot);
   assign calls       = elev.interior_panel | elev.exterior_panel;

   // A call for the floor whose door is already open is not latched; it
   // only extends the dwell.
   assign door_recall = (state_reg == DOOR_OPEN) && |(calls & here_onehot);
   assign latch_calls = (state_reg == DOOR_OPEN) ? (calls & ~here_onehot) : calls;

   // SCAN choice: keep going while calls remain ahead, else turn around,
   // else rest.
   always_comb begin
      pick_state = IDLE;
      pick_dir   = direction_reg;
      if (direction_reg ? above : below) begin
         pick_state = direction_reg ? MOVE_UP : MOVE_DOWN;
      end else if (direction_reg ? below : above) begin
         pick_state = direction_reg ? MOVE_DOWN : MOVE_UP;
         pick_dir   = ~direction_reg;
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= IDLE;
         floor_reg      <= '0;
         requests_reg   <= '0;
         direction_reg  <= 1'b1;
         travel_cnt_reg <= '0;
         door_cnt_reg   <= '0;
         engine_reg     <= 2'b00;
         doors_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         floor_reg      <= floor_next;
         requests_reg   <= requests_next;
         direction_reg  <= direction_next;
         travel_cnt_reg <= travel_cnt_next;
         door_cnt_reg   <= door_cnt_next;
         engine_reg     <= engine_next;
         doors_reg      <= doors_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next      = state_reg;
      floor_next      = floor_reg;
      direction_next  = direction_reg;
      travel_cnt_next = travel_cnt_reg;
      door_cnt_next   = door_cnt_reg;
      clear_mask      = '0;
      arrive_onehot   = '0;
      if (!halted) begin
         case (state_reg)
            IDLE: begin
               if (here) begin
                  state_next = DOOR_OPEN;
                  clear_mask = here_onehot;
               end else begin
                  state_next     = pick_state;
                  direction_next = pick_dir;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (travel_cnt_reg == TRAVEL_LAST) begin
                  travel_cnt_next = '0;
                  if (state_reg == MOVE_UP && floor_reg != TOP_FLOOR)
                     floor_next = floor_reg + FW'(1);
                  else if (state_reg == MOVE_DOWN && floor_reg != '0)
                     floor_next = floor_reg - FW'(1);
                  // Stop only if the floor just reached was already pending.
                  arrive_onehot = ONE << floor_next;
                  if (|(requests_reg & arrive_onehot)) begin
                     state_next = DOOR_OPEN;
                     clear_mask = arrive_onehot;
                  end
               end else begin
                  travel_cnt_next = travel_cnt_reg + TCW'(1);
               end
            end
            DOOR_OPEN: begin
               if (door_recall) begin
                  door_cnt_next = '0;
               end else if (door_cnt_reg == DOOR_LAST) begin
                  door_cnt_next  = '0;
                  state_next     = pick_state;
                  direction_next = pick_dir;
               end else begin
                  door_cnt_next = door_cnt_reg + DCW'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
      requests_next = (requests_reg | latch_calls) & ~clear_mask;
   end

   // Output logic, registered alongside the state.
   always_comb begin
      engine_next = 2'b00;
      doors_next  = '0;
      case (state_next)
         MOVE_UP:   engine_next = halted ? 2'b00 : 2'b10;
         MOVE_DOWN: engine_next = halted ? 2'b00 : 2'b11;
         DOOR_OPEN: doors_next  = ONE << floor_next;
         default:   engine_next = 2'b00;
      endcase
   end

   assign elev.engine        = engine_reg;
   assign elev.doors         = doors_reg;
   assign elev.current_floor = floor_reg;
   assign elev.requests      = requests_reg;
   assign elev.direction     = direction_reg;
endmodule
